// File: rtl/ahb_pixel_mem_slave.sv
// ahb_pixel_mem_slave
// AHB-Lite-style pixel memory slave. It holds the input frame and the processed
// output frame, serves bus reads and writes with programmable wait states, and
// tracks the output write window: first address, committed-write count and completion.
// A backdoor port preloads pixels without touching the counters.
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   haddr/htrans/hwrite address phase (pixel-word address, transfer type, direction)
//   hwdata              write data phase, pixel LSB-aligned, upper bits ignored
//   hrdata/hready       read data (pad bits zero) and data-phase completion
//   ld_en/ld_addr/ld_data  backdoor pixel load
//   wr_start(_vld)      address of the first committed bus write
//   wr_cnt/err_cnt/done committed writes, out-of-range accesses, sticky completion
module ahb_pixel_mem_slave #(
  parameter int IMG_W   = 428,
  parameter int IMG_H   = 428,
  parameter int DEPTH   = 2 * IMG_W * IMG_H,
  parameter int ADDR_W  = 19,
  parameter int CH      = 3,
  parameter int CH_W    = 8,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1,
  parameter int EXP_WR  = (IMG_H - 2) * (IMG_W - 2)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [ADDR_W-1:0]    haddr,
  input  logic [1:0]           htrans,
  input  logic                 hwrite,
  input  logic [31:0]          hwdata,
  output logic [31:0]          hrdata,
  output logic                 hready,
  input  logic                 ld_en,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [CH*CH_W-1:0]   ld_data,
  output logic [ADDR_W-1:0]    wr_start,
  output logic                 wr_start_vld,
  output logic [31:0]          wr_cnt,
  output logic [15:0]          err_cnt,
  output logic                 done
);

  localparam int PIX_W = CH * CH_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
  localparam logic [31:0] EXP_WR_L = EXP_WR[31:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  logic [PIX_W-1:0] mem [0:DEPTH-1];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic              hready_q, hready_d;
  logic [31:0]       hrdata_q, hrdata_d;
  logic [ADDR_W-1:0] wr_start_q, wr_start_d;
  logic              wr_start_vld_q, wr_start_vld_d;
  logic [31:0]       wr_cnt_q, wr_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              done_q, done_d;

  logic              capture_s;
  logic              closing_s;
  logic              commit_s;
  logic              fwd_s;
  logic [3:0]        wait_s;
  logic              unused_in_s;

  // Only the pixel bits of hwdata and the NONSEQ/SEQ bit of htrans matter.
  assign unused_in_s = ^{hwdata, htrans[0]};

  // Next-state logic: transfer capture, wait countdown, commit and tracking.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    write_d        = write_q;
    hrdata_d       = hrdata_q;
    wr_start_d     = wr_start_q;
    wr_start_vld_d = wr_start_vld_q;
    wr_cnt_d       = wr_cnt_q;
    err_cnt_d      = err_cnt_q;
    done_d         = done_q | (wr_cnt_q == EXP_WR_L);
    capture_s      = hready_q & htrans[1];
    closing_s      = (state_q == ST_DATA);
    commit_s       = closing_s & write_q & in_range(addr_q);
    fwd_s          = commit_s & (addr_q == haddr);
    wait_s         = hwrite ? 4'(WR_WAIT) : 4'(RD_WAIT);

    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_DATA;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DATA: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A capture overrides the fall-through above (it is only possible from IDLE or DATA).
    if (capture_s) begin
      addr_d  = haddr;
      write_d = hwrite;
      cnt_d   = wait_s;
      if (wait_s == 4'd0) begin
        state_d = ST_DATA;
      end else begin
        state_d = ST_WAIT;
      end
      if (hwrite) begin
        hrdata_d = hrdata_q;
      end else if (!in_range(haddr)) begin
        hrdata_d = 32'd0;
      end else if (fwd_s) begin
        // The write closing at this edge has not reached mem yet.
        hrdata_d = 32'(hwdata[PIX_W-1:0]);
      end else begin
        hrdata_d = 32'(mem[haddr[IDX_W-1:0]]);
      end
    end else begin
      hrdata_d = hrdata_q;
    end

    if (commit_s) begin
      if (!wr_start_vld_q) begin
        wr_start_d     = addr_q;
        wr_start_vld_d = 1'b1;
      end else begin
        wr_start_d = wr_start_q;
      end
      if (wr_cnt_q != 32'hFFFF_FFFF) begin
        wr_cnt_d = wr_cnt_q + 32'd1;
      end else begin
        wr_cnt_d = wr_cnt_q;
      end
    end else if (closing_s && !in_range(addr_q)) begin
      if (err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      wr_cnt_d = wr_cnt_q;
    end

    hready_d = (state_d != ST_WAIT);
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      addr_q         <= {ADDR_W{1'b0}};
      write_q        <= 1'b0;
      hready_q       <= 1'b1;
      hrdata_q       <= 32'd0;
      wr_start_q     <= {ADDR_W{1'b0}};
      wr_start_vld_q <= 1'b0;
      wr_cnt_q       <= 32'd0;
      err_cnt_q      <= 16'd0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      write_q        <= write_d;
      hready_q       <= hready_d;
      hrdata_q       <= hrdata_d;
      wr_start_q     <= wr_start_d;
      wr_start_vld_q <= wr_start_vld_d;
      wr_cnt_q       <= wr_cnt_d;
      err_cnt_q      <= err_cnt_d;
      done_q         <= done_d;
    end
  end

  // Pixel storage, not reset; the bus write is issued last so it wins a collision.
  always_ff @(posedge clk) begin
    if (ld_en && in_range(ld_addr)) begin
      mem[ld_addr[IDX_W-1:0]] <= ld_data;
    end
    if (commit_s) begin
      mem[addr_q[IDX_W-1:0]] <= hwdata[PIX_W-1:0];
    end
  end

  assign hrdata       = hrdata_q;
  assign hready       = hready_q;
  assign wr_start     = wr_start_q;
  assign wr_start_vld = wr_start_vld_q;
  assign wr_cnt       = wr_cnt_q;
  assign err_cnt      = err_cnt_q;
  assign done         = done_q;

endmodule

// File: tb/tb_ahb_pixel_mem_slave.sv
// Testbench for ahb_pixel_mem_slave: directed cases with literal expectations,
// then randomized bus traffic and backdoor loads checked every cycle against a
// transaction-level model of the slave.
module tb_ahb_pixel_mem_slave;
  localparam int IMG_W   = 8;
  localparam int IMG_H   = 8;
  localparam int DEPTH   = 2 * IMG_W * IMG_H;
  localparam int ADDR_W  = 8;
  localparam int CH      = 3;
  localparam int CH_W    = 8;
  localparam int RD_WAIT = 0;
  localparam int WR_WAIT = 2;
  localparam int EXP_WR  = (IMG_H - 2) * (IMG_W - 2);
  localparam int IDX_W   = 7;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [31:0]       hwdata;
  logic [31:0]       hrdata;
  logic              hready;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [23:0]       ld_data;
  logic [ADDR_W-1:0] wr_start;
  logic              wr_start_vld;
  logic [31:0]       wr_cnt;
  logic [15:0]       err_cnt;
  logic              done;

  ahb_pixel_mem_slave #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CH(CH),
    .CH_W(CH_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .EXP_WR(EXP_WR)
  ) u_dut (
    .clk(clk), .n_rst(n_rst), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data), .wr_start(wr_start),
    .wr_start_vld(wr_start_vld), .wr_cnt(wr_cnt), .err_cnt(err_cnt), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic ld_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding transfer with a count of wait cycles left.
  logic [23:0]       m_mem [0:DEPTH-1];
  logic              m_pv;
  logic [ADDR_W-1:0] m_pa;
  logic              m_pw;
  int                m_left;
  logic [31:0]       m_hrdata;
  logic [ADDR_W-1:0] m_start;
  logic              m_vld;
  logic [31:0]       m_cnt;
  logic [15:0]       m_err;
  logic              m_done;
  logic              m_rdy;
  logic              m_close;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_pv <= 1'b0; m_left <= 0; m_hrdata <= 32'd0; m_start <= 8'd0; m_vld <= 1'b0;
      m_cnt <= 32'd0; m_err <= 16'd0; m_done <= 1'b0; m_pa <= 8'd0; m_pw <= 1'b0;
    end else begin
      m_rdy   = !m_pv || (m_left == 0);
      m_close = m_pv && (m_left == 0);
      if (ld_en && ld_addr < DEPTH) m_mem[ld_addr[IDX_W-1:0]] <= ld_data;
      if (m_close) begin
        if (m_pa < DEPTH) begin
          if (m_pw) begin
            m_mem[m_pa[IDX_W-1:0]] <= hwdata[23:0];
            if (!m_vld) begin
              m_start <= m_pa;
              m_vld   <= 1'b1;
            end
            if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
          end
        end else if (m_err != 16'hFFFF) begin
          m_err <= m_err + 16'd1;
        end
      end
      m_done <= m_done || (m_cnt == EXP_WR);
      if (m_rdy && htrans[1]) begin
        m_pv   <= 1'b1;
        m_pa   <= haddr;
        m_pw   <= hwrite;
        m_left <= hwrite ? WR_WAIT : RD_WAIT;
        if (!hwrite) begin
          if (haddr >= DEPTH) m_hrdata <= 32'd0;
          else if (m_close && m_pw && m_pa == haddr) m_hrdata <= {8'd0, hwdata[23:0]};
          else m_hrdata <= {8'd0, m_mem[haddr[IDX_W-1:0]]};
        end
      end else if (m_close) begin
        m_pv <= 1'b0;
      end else if (m_pv) begin
        m_left <= m_left - 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (n_rst && chk_en) begin
      check("hready", {31'd0, hready}, {31'd0, (!m_pv || m_left == 0)});
      check("hrdata", hrdata, m_hrdata);
      check("wr_start", {24'd0, wr_start}, {24'd0, m_start});
      check("wr_start_vld", {31'd0, wr_start_vld}, {31'd0, m_vld});
      check("wr_cnt", wr_cnt, m_cnt);
      check("err_cnt", {16'd0, err_cnt}, {16'd0, m_err});
      check("done", {31'd0, done}, {31'd0, m_done});
    end
  end

  task automatic drive_ld();
    if (ld_rand) begin
      ld_en   = ($urandom_range(0, 3) == 0);
      ld_addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      ld_data = 24'($urandom);
    end else begin
      ld_en = 1'b0;
    end
  endtask

  // Present an address phase and hold it until the slave accepts it.
  task automatic do_cycle(input logic [1:0] t, input logic w, input logic [7:0] a, input logic [31:0] d);
    logic acc;
    int guard;
    htrans = t; hwrite = w; haddr = a;
    acc = 1'b0; guard = 0;
    while (!acc) begin
      @(negedge clk);
      acc = hready;
      @(posedge clk);
      #1;
      drive_ld();
      guard++;
      if (!acc && guard > 20) begin
        checks++; errors++;
        $display("FAIL bus_timeout: got hready=0 for %0d cycles expected completion", guard);
        acc = 1'b1;
      end
    end
    if (t[1] && w) hwdata = d;
    else hwdata = $urandom();
  endtask

  task automatic bd_load(input logic [7:0] a, input logic [23:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  initial begin
    htrans = 2'b00; hwrite = 1'b0; haddr = 8'd0; hwdata = 32'd0;
    ld_en = 1'b0; ld_addr = 8'd0; ld_data = 24'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hready", {31'd0, hready}, 32'd1);
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_wr_cnt", wr_cnt, 32'd0);
    check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_vld", {31'd0, wr_start_vld}, 32'd0);
    n_rst = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) bd_load(8'(i), 24'($urandom));
    bd_load(8'd5, 24'h112233);

    // Zero-wait read of a backdoor-loaded pixel.
    do_cycle(2'b10, 1'b0, 8'd5, 32'd0);
    check("rd5_hready", {31'd0, hready}, 32'd1);
    do_cycle(2'b00, 1'b0, 8'd0, 32'd0);
    check("rd5_hrdata", hrdata, 32'h0011_2233);

    // Two back-to-back writes with two wait cycles each.
    do_cycle(2'b10, 1'b1, 8'd100, 32'h00AA_BBCC);
    check("wr100_wait", {31'd0, hready}, 32'd0);
    do_cycle(2'b11, 1'b1, 8'd101, 32'h7744_5566);
    do_cycle(2'b00, 1'b0, 8'd0, 32'd0);
    check("wr_start", {24'd0, wr_start}, 32'd100);
    check("wr_start_vld", {31'd0, wr_start_vld}, 32'd1);
    check("wr_cnt_2", wr_cnt, 32'd2);
    do_cycle(2'b10, 1'b0, 8'd100, 32'd0);
    do_cycle(2'b00, 1'b0, 8'd0, 32'd0);
    check("rd100", hrdata, 32'h00AA_BBCC);

    // Read captured on the same edge the write to that address commits.
    do_cycle(2'b10, 1'b1, 8'd7, 32'hFF01_0203);
    do_cycle(2'b10, 1'b0, 8'd7, 32'd0);
    do_cycle(2'b00, 1'b0, 8'd0, 32'd0);
    check("fwd7", hrdata, 32'h0001_0203);

    // Out-of-range read and write.
    do_cycle(2'b10, 1'b0, 8'(DEPTH + 3), 32'd0);
    do_cycle(2'b10, 1'b1, 8'(DEPTH), 32'h0012_3456);
    do_cycle(2'b00, 1'b0, 8'd0, 32'd0);
    check("oor_hrdata", hrdata, 32'd0);
    check("oor_err", {16'd0, err_cnt}, 32'd2);
    check("oor_wr_cnt", wr_cnt, 32'd3);

    // Run the write count up to completion and past it.
    for (int i = 0; i < 32; i++) do_cycle((i == 0) ? 2'b10 : 2'b11, 1'b1, 8'(64 + i), $urandom());
    do_cycle(2'b00, 1'b0, 8'd0, 32'd0);
    check("cnt35", wr_cnt, 32'd35);
    do_cycle(2'b10, 1'b1, 8'd120, $urandom());
    do_cycle(2'b00, 1'b0, 8'd0, 32'd0);
    check("cnt36", wr_cnt, 32'd36);
    check("done_not_yet", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    check("done_rise", {31'd0, done}, 32'd1);
    do_cycle(2'b10, 1'b1, 8'd121, $urandom());
    do_cycle(2'b00, 1'b0, 8'd0, 32'd0);
    check("cnt37", wr_cnt, 32'd37);
    check("done_sticky", {31'd0, done}, 32'd1);

    // Reset during the wait of a write: no commit, all outputs back to reset values.
    bd_load(8'd9, 24'h5A5A5A);
    do_cycle(2'b10, 1'b1, 8'd9, 32'h0012_3456);
    htrans = 2'b00;
    check("wr9_wait", {31'd0, hready}, 32'd0);
    #3;
    n_rst = 1'b0;
    #1;
    check("mid_rst_hready", {31'd0, hready}, 32'd1);
    check("mid_rst_hrdata", hrdata, 32'd0);
    check("mid_rst_wr_cnt", wr_cnt, 32'd0);
    check("mid_rst_err", {16'd0, err_cnt}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_vld", {31'd0, wr_start_vld}, 32'd0);
    check("mid_rst_start", {24'd0, wr_start}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    do_cycle(2'b10, 1'b0, 8'd9, 32'd0);
    do_cycle(2'b00, 1'b0, 8'd0, 32'd0);
    check("rd9_kept", hrdata, 32'h005A_5A5A);

    // Randomized traffic with backdoor loads mixed in.
    ld_rand = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      int r;
      int ar;
      logic [1:0] t;
      logic [7:0] a;
      r = $urandom_range(0, 19);
      if (r < 3) t = 2'b00;
      else if (r == 3) t = 2'b01;
      else t = (r < 11) ? 2'b10 : 2'b11;
      ar = $urandom_range(0, 9);
      if (ar == 0) a = 8'($urandom_range(DEPTH, 255));
      else if (ar < 5) a = 8'($urandom_range(0, 15));
      else a = 8'($urandom_range(0, DEPTH - 1));
      do_cycle(t, 1'($urandom_range(0, 1)), a, $urandom());
    end
    ld_rand = 1'b0;
    do_cycle(2'b00, 1'b0, 8'd0, 32'd0);
    do_cycle(2'b00, 1'b0, 8'd0, 32'd0);
    // Read back every in-range pixel through the bus.
    for (int i = 0; i < DEPTH; i++) do_cycle(2'b10, 1'b0, 8'(i), 32'd0);
    do_cycle(2'b00, 1'b0, 8'd0, 32'd0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
